fifo_flags: RTL and testbench

- Synchronous FIFO that buffers LINE_SIZE-bit transaction words for the referee stage.
- The referee consumes this FIFO's almost_full, almost_empty and empty flags, and drives push/pop into it.
- One instance is used per virtual channel; four instances sit in front of and behind the referee.
- Flag thresholds are loaded from the main control FSM while it is in INIT.

---
 rtl/fifo_flags_if.sv | 28 ++
 rtl/fifo_flags.sv | 110 +++++++++++
 tb/tb_fifo_flags.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_flags_if.sv
// Referee-side bundle for one fifo_flags channel: push/pop requests, data and status flags.
// The referee drives through master; the FIFO implements slave.
interface fifo_flags_if #(
    parameter int unsigned LINE_SIZE  = 12,
    parameter int unsigned ADDR_WIDTH = 3
);
    logic                  push;
    logic                  pop;
    logic [LINE_SIZE-1:0]  data_in;
    logic [LINE_SIZE-1:0]  data_out;
    logic                  valid_out;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic [ADDR_WIDTH:0]   count;
    logic                  error;

    modport master (
        output push, pop, data_in,
        input  data_out, valid_out, full, empty, almost_full, almost_empty, count, error
    );

    modport slave (
        input  push, pop, data_in,
        output data_out, valid_out, full, empty, almost_full, almost_empty, count, error
    );
endinterface

// File: rtl/fifo_flags.sv
// Synchronous FIFO with programmable almost-full/almost-empty flags and a sticky
// overflow/underflow error; requests are honoured only in IDLE/ACTIVE main states.
module fifo_flags #(
    parameter int unsigned LINE_SIZE  = 12,
    parameter int unsigned ADDR_WIDTH = 3,
    parameter int unsigned DEF_AF_TH  = 6,
    parameter int unsigned DEF_AE_TH  = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [3:0]            state,
    input  logic [ADDR_WIDTH-1:0] af_th,
    input  logic [ADDR_WIDTH-1:0] ae_th,
    fifo_flags_if.slave           bus
);
    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0]   DEPTH_CNT = DEPTH;
    localparam logic [ADDR_WIDTH:0]   CNT_ONE   = 1;
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = 1;
    localparam logic [ADDR_WIDTH-1:0] AF_RST    = DEF_AF_TH[ADDR_WIDTH-1:0];
    localparam logic [ADDR_WIDTH-1:0] AE_RST    = DEF_AE_TH[ADDR_WIDTH-1:0];

    typedef enum logic [3:0] {
        ST_RESET  = 4'b0001,
        ST_INIT   = 4'b0010,
        ST_IDLE   = 4'b0100,
        ST_ACTIVE = 4'b1000
    } main_state_e;

    logic [LINE_SIZE-1:0]  mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH:0]   count_r;
    logic [ADDR_WIDTH-1:0] af_th_r;
    logic [ADDR_WIDTH-1:0] ae_th_r;
    logic [LINE_SIZE-1:0]  data_out_r;
    logic                  valid_r;
    logic                  error_r;

    logic in_init;
    logic req_en;
    logic full_c;
    logic empty_c;
    logic do_push;
    logic do_pop;
    logic bad_req;

    // Any state that is not exactly one of the one-hot codes behaves like RESET.
    assign in_init = (state == ST_INIT);
    assign req_en  = !reset && ((state == ST_IDLE) || (state == ST_ACTIVE));

    assign full_c  = (count_r == DEPTH_CNT);
    assign empty_c = (count_r == '0);

    // A pop on an empty FIFO is rejected even if a push lands on the same edge.
    always_comb begin
        do_pop  = req_en && bus.pop && !empty_c;
        do_push = req_en && bus.push && (!full_c || do_pop);
        bad_req = req_en && ((bus.pop && empty_c) || (bus.push && full_c && !do_pop));
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= bus.data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_r    <= '0;
            data_out_r <= '0;
            valid_r    <= 1'b0;
            error_r    <= 1'b0;
            af_th_r    <= AF_RST;
            ae_th_r    <= AE_RST;
        end else begin
            if (in_init) begin
                af_th_r <= af_th;
                ae_th_r <= ae_th;
            end
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                data_out_r <= mem[rd_ptr];
                rd_ptr     <= rd_ptr + PTR_ONE;
            end
            valid_r <= do_pop;
            case ({do_push, do_pop})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
            if (bad_req) begin
                error_r <= 1'b1;
            end
        end
    end

    assign bus.data_out     = data_out_r;
    assign bus.valid_out    = valid_r;
    assign bus.count        = count_r;
    assign bus.error        = error_r;
    assign bus.full         = full_c;
    assign bus.empty        = empty_c;
    assign bus.almost_full  = (count_r >= {1'b0, af_th_r});
    assign bus.almost_empty = (count_r <= {1'b0, ae_th_r});
endmodule

// File: tb/tb_fifo_flags.sv
// Bench for fifo_flags: vector table, directed corner sequences and a random run,
// all compared against a queue-based reference model.
module tb_fifo_flags;
    logic       clk;
    logic       reset;
    logic [3:0] state;
    logic [2:0] af_th;
    logic [2:0] ae_th;

    int tests;
    int fails;

    fifo_flags_if #(.LINE_SIZE(12), .ADDR_WIDTH(3)) bus ();

    fifo_flags #(
        .LINE_SIZE (12),
        .ADDR_WIDTH(3),
        .DEF_AF_TH (6),
        .DEF_AE_TH (2)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .state(state),
        .af_th(af_th),
        .ae_th(ae_th),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: occupancy is simply the queue length.
    logic [11:0] m_q[$];
    logic [11:0] m_dout;
    logic        m_valid;
    logic        m_err;
    int          m_af;
    int          m_ae;

    typedef struct {
        logic        rst;
        logic [3:0]  st;
        logic [2:0]  a;
        logic [2:0]  e;
        logic        ps;
        logic        pp;
        logic [11:0] din;
        int          cnt;
        logic        v;
        logic [11:0] d;
        logic        er;
        logic        afl;
        logic        ael;
        logic        fl;
        logic        em;
    } vec_t;

    vec_t vecs[21];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_update(input logic rst, input logic [3:0] st, input logic [2:0] a,
                                input logic [2:0] e, input logic ps, input logic pp,
                                input logic [11:0] din);
        bit pop_ok;
        bit push_ok;
        if (rst) begin
            m_q.delete();
            m_dout = '0;
            m_valid = 1'b0;
            m_err = 1'b0;
            m_af = 6;
            m_ae = 2;
        end else begin
            if (st == 4'b0010) begin
                m_af = a;
                m_ae = e;
            end
            if (st == 4'b0100 || st == 4'b1000) begin
                pop_ok  = pp && (m_q.size() > 0);
                push_ok = ps && (m_q.size() < 8 || pop_ok);
                if (pop_ok) m_dout = m_q.pop_front();
                m_valid = pop_ok;
                if (push_ok) m_q.push_back(din);
                if ((pp && !pop_ok) || (ps && !push_ok)) m_err = 1'b1;
            end else begin
                m_valid = 1'b0;
            end
        end
    endtask

    task automatic compare_model();
        int n;
        n = m_q.size();
        check("m_count", bus.count, n);
        check("m_empty", bus.empty, n == 0);
        check("m_full", bus.full, n == 8);
        check("m_afull", bus.almost_full, n >= m_af);
        check("m_aempty", bus.almost_empty, n <= m_ae);
        check("m_valid", bus.valid_out, m_valid);
        check("m_error", bus.error, m_err);
        check("m_dout", bus.data_out, m_dout);
    endtask

    task automatic step(input logic rst, input logic [3:0] st, input logic [2:0] a,
                        input logic [2:0] e, input logic ps, input logic pp,
                        input logic [11:0] din);
        reset = rst;
        state = st;
        af_th = a;
        ae_th = e;
        bus.push = ps;
        bus.pop = pp;
        bus.data_in = din;
        @(posedge clk);
        model_update(rst, st, a, e, ps, pp, din);
        #1;
        compare_model();
    endtask

    function automatic vec_t mk(logic rst, logic [3:0] st, logic ps, logic pp, logic [11:0] din,
                                int cnt, logic v, logic [11:0] d, logic er,
                                logic afl, logic ael, logic fl, logic em);
        vec_t r;
        r.rst = rst; r.st = st; r.a = 3'd5; r.e = 3'd1;
        r.ps = ps; r.pp = pp; r.din = din;
        r.cnt = cnt; r.v = v; r.d = d; r.er = er;
        r.afl = afl; r.ael = ael; r.fl = fl; r.em = em;
        return r;
    endfunction

    initial begin
        tests = 0;
        fails = 0;
        m_af = 6;
        m_ae = 2;
        m_err = 1'b0;
        m_valid = 1'b0;
        m_dout = '0;

        // Reset, threshold load (af=5, ae=1), almost flags, ordering and latency.
        vecs[0]  = mk(1, 4'h1, 0, 0, 12'h000, 0, 0, 12'h000, 0, 0, 1, 0, 1);
        vecs[1]  = mk(1, 4'h1, 0, 0, 12'h000, 0, 0, 12'h000, 0, 0, 1, 0, 1);
        vecs[2]  = mk(0, 4'h2, 0, 0, 12'h000, 0, 0, 12'h000, 0, 0, 1, 0, 1);
        vecs[3]  = mk(0, 4'h8, 1, 0, 12'h101, 1, 0, 12'h000, 0, 0, 1, 0, 0);
        vecs[4]  = mk(0, 4'h8, 1, 0, 12'h102, 2, 0, 12'h000, 0, 0, 0, 0, 0);
        vecs[5]  = mk(0, 4'h8, 1, 0, 12'h103, 3, 0, 12'h000, 0, 0, 0, 0, 0);
        vecs[6]  = mk(0, 4'h8, 1, 0, 12'h104, 4, 0, 12'h000, 0, 0, 0, 0, 0);
        vecs[7]  = mk(0, 4'h8, 1, 0, 12'h105, 5, 0, 12'h000, 0, 1, 0, 0, 0);
        vecs[8]  = mk(0, 4'h8, 0, 1, 12'h000, 4, 1, 12'h101, 0, 0, 0, 0, 0);
        vecs[9]  = mk(0, 4'h8, 0, 1, 12'h000, 3, 1, 12'h102, 0, 0, 0, 0, 0);
        vecs[10] = mk(0, 4'h8, 0, 1, 12'h000, 2, 1, 12'h103, 0, 0, 0, 0, 0);
        vecs[11] = mk(0, 4'h8, 0, 1, 12'h000, 1, 1, 12'h104, 0, 0, 1, 0, 0);
        vecs[12] = mk(0, 4'h8, 0, 1, 12'h000, 0, 1, 12'h105, 0, 0, 1, 0, 1);
        vecs[13] = mk(0, 4'h8, 0, 0, 12'h000, 0, 0, 12'h105, 0, 0, 1, 0, 1);
        vecs[14] = mk(0, 4'h8, 1, 0, 12'hDE4, 1, 0, 12'h105, 0, 0, 1, 0, 0);
        vecs[15] = mk(0, 4'h8, 1, 0, 12'h96C, 2, 0, 12'h105, 0, 0, 0, 0, 0);
        vecs[16] = mk(0, 4'h8, 1, 0, 12'h16E, 3, 0, 12'h105, 0, 0, 0, 0, 0);
        vecs[17] = mk(0, 4'h8, 0, 1, 12'h000, 2, 1, 12'hDE4, 0, 0, 0, 0, 0);
        vecs[18] = mk(0, 4'h8, 0, 1, 12'h000, 1, 1, 12'h96C, 0, 0, 1, 0, 0);
        vecs[19] = mk(0, 4'h8, 0, 1, 12'h000, 0, 1, 12'h16E, 0, 0, 1, 0, 1);
        vecs[20] = mk(0, 4'h8, 0, 0, 12'h000, 0, 0, 12'h16E, 0, 0, 1, 0, 1);

        for (int i = 0; i < 21; i++) begin
            step(vecs[i].rst, vecs[i].st, vecs[i].a, vecs[i].e, vecs[i].ps, vecs[i].pp, vecs[i].din);
            check($sformatf("v%0d_count", i), bus.count, vecs[i].cnt);
            check($sformatf("v%0d_valid", i), bus.valid_out, vecs[i].v);
            check($sformatf("v%0d_dout", i), bus.data_out, vecs[i].d);
            check($sformatf("v%0d_error", i), bus.error, vecs[i].er);
            check($sformatf("v%0d_afull", i), bus.almost_full, vecs[i].afl);
            check($sformatf("v%0d_aempty", i), bus.almost_empty, vecs[i].ael);
            check($sformatf("v%0d_full", i), bus.full, vecs[i].fl);
            check($sformatf("v%0d_empty", i), bus.empty, vecs[i].em);
        end

        // Fill and overflow.
        step(1, 4'h1, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 9; i++) begin
            step(0, 4'h8, 0, 0, 1, 0, 12'(i));
            if (i == 8) begin
                check("fill_full8", bus.full, 1);
                check("fill_err8", bus.error, 0);
            end
        end
        check("ovf_error", bus.error, 1);
        check("ovf_count", bus.count, 8);
        for (int i = 1; i <= 8; i++) begin
            step(0, 4'h8, 0, 0, 0, 1, 0);
            check($sformatf("ovf_pop%0d", i), bus.data_out, i);
        end

        // Wrap-around and push+pop while full.
        step(1, 4'h1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) step(0, 4'h8, 0, 0, 1, 0, 12'h200 + 12'(i));
        for (int i = 0; i < 6; i++) step(0, 4'h8, 0, 0, 0, 1, 0);
        for (int i = 0; i < 8; i++) step(0, 4'h8, 0, 0, 1, 0, 12'h300 + 12'(i));
        check("wrap_full", bus.full, 1);
        step(0, 4'h8, 0, 0, 1, 1, 12'h3A0);
        check("fpp_count", bus.count, 8);
        check("fpp_dout", bus.data_out, 12'h300);
        check("fpp_valid", bus.valid_out, 1);
        check("fpp_error", bus.error, 0);
        for (int i = 1; i <= 8; i++) begin
            step(0, 4'h8, 0, 0, 0, 1, 0);
            check($sformatf("wrap_pop%0d", i), bus.data_out, (i == 8) ? 12'h3A0 : 12'h300 + 12'(i));
        end

        // Empty push+pop: push lands, pop is an underflow.
        step(1, 4'h1, 0, 0, 0, 0, 0);
        step(0, 4'h8, 0, 0, 1, 1, 12'h578);
        check("epp_count", bus.count, 1);
        check("epp_valid", bus.valid_out, 0);
        check("epp_error", bus.error, 1);
        step(0, 4'h8, 0, 0, 0, 1, 0);
        check("epp_dout", bus.data_out, 12'h578);
        check("epp_valid2", bus.valid_out, 1);

        // Gating in INIT, then mid-operation reset.
        step(1, 4'h1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 4'h2, 3'd6, 3'd2, 1, 0, 12'hAAA);
        check("gate_count", bus.count, 0);
        for (int i = 0; i < 4; i++) step(0, 4'h8, 0, 0, 1, 0, 12'h400 + 12'(i));
        step(1, 4'h8, 0, 0, 1, 1, 12'h4FF);
        check("mrst_count", bus.count, 0);
        check("mrst_empty", bus.empty, 1);
        check("mrst_valid", bus.valid_out, 0);
        check("mrst_error", bus.error, 0);
        step(0, 4'h8, 0, 0, 0, 1, 0);
        check("mrst_underflow", bus.error, 1);

        // Random traffic, including odd state codes and occasional resets.
        for (int i = 0; i < 600; i++) begin
            logic [3:0] st;
            int r;
            r = $urandom_range(0, 19);
            if (r < 9) st = 4'h8;
            else if (r < 15) st = 4'h4;
            else if (r < 17) st = 4'h2;
            else if (r < 18) st = 4'h1;
            else st = 4'($urandom_range(0, 15));
            step(($urandom_range(0, 79) == 0), st, 3'($urandom), 3'($urandom),
                 ($urandom_range(0, 99) < 55), ($urandom_range(0, 99) < 45), 12'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
